// File: rtl/ram_responder.sv
// ram_responder: single-word RAM responder with programmable wait states.
// Requests are latched in IDLE, held through WAIT, and completed in ACCESS.
// Any change or drop of the request before completion abandons the access.
module ram_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CW    = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]           state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [ADDR_BITS-1:0] lat_idx, lat_idx_n;
  logic                 lat_op, lat_op_n;
  logic                 mem_we;
  logic [31:0]          mem [DEPTH];

  logic                 req;
  logic                 op;
  logic [ADDR_BITS-1:0] idx;
  logic                 abort;
  logic                 unused_addr_bits;

  // Decode the live request; write wins when both strobes are high.
  always_comb begin
    req   = Ren | Wen;
    op    = Wen;
    idx   = ramaddr[ADDR_BITS+1:2];
    abort = !req || (idx != lat_idx) || (op != lat_op);
  end

  assign unused_addr_bits = ^{ramaddr[31:ADDR_BITS+2], ramaddr[1:0]};

  // State, wait counter and latched request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_idx <= '0;
      lat_op  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lat_idx <= lat_idx_n;
      lat_op  <= lat_op_n;
    end
  end

  // Next-state, busy/read-data and write-enable decode.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lat_idx_n = lat_idx;
    lat_op_n  = lat_op;
    busy_o    = req;
    ramload   = 32'h0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          lat_idx_n = idx;
          lat_op_n  = op;
          cnt_n     = CW'(LATENCY);
          state_n   = (LATENCY > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          busy_o = 1'b1;
          cnt_n  = cnt - CW'(1);
          if (cnt == CW'(1)) state_n = ACCESS;
        end
      end
      ACCESS: begin
        state_n = IDLE;
        if (!abort) begin
          busy_o = 1'b0;
          if (lat_op) mem_we = 1'b1;
          else        ramload = mem[lat_idx];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Storage: cleared on reset, written on the edge leaving a write ACCESS.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[lat_idx] <= ramstore;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_ram_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        Ren, Wen;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] load, load0;
  logic        busy, busy0;

  int pass_cnt = 0;
  int total    = 0;

  always #5 CLK = ~CLK;

  ram_responder #(.ADDR_BITS(10), .LATENCY(2)) dut (
    .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(load), .busy_o(busy)
  );

  ram_responder #(.ADDR_BITS(10), .LATENCY(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(load0), .busy_o(busy0)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; Ren = 1'b0; Wen = 1'b0; ramaddr = '0; ramstore = '0;
    step(); step();
    nRST = 1'b1;
    step();
  endtask

  // Issue a request at posedge+1 and hold it until busy falls (bounded).
  // rd = ramload in the completion cycle, nbusy = cycles with busy high,
  // early = OR of ramload over busy cycles. Unless hold, drops the request after.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input bit sel0, input bit hold,
                           output logic [31:0] rd, output int nbusy,
                           output logic [31:0] early);
    bit done;
    Ren = r; Wen = w; ramaddr = a; ramstore = d;
    nbusy = 0; early = 32'h0; rd = 32'hxxxx_xxxx; done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((sel0 ? busy0 : busy) === 1'b0) begin
        rd = sel0 ? load0 : load;
        done = 1'b1;
        break;
      end
      nbusy++;
      early = early | (sel0 ? load0 : load);
      step();
    end
    if (!done) nbusy = 999;
    if (!hold) begin
      step();
      Ren = 1'b0; Wen = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy); else pass_cnt++;
    total++; if (load !== 32'h0) $display("FAIL reset_load actual=%h required=00000000", load); else pass_cnt++;
    total++; if (busy0 !== 1'b0) $display("FAIL reset_busy0 actual=%b required=0", busy0); else pass_cnt++;
    Ren = 1'b1; ramaddr = 32'h8;
    #1;
    total++; if (busy !== 1'b1) $display("FAIL idle_busy_req actual=%b required=1", busy); else pass_cnt++;
    Ren = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    logic [31:0] rd, early; int nb;
    do_access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, rd, nb, early);
    total++; if (nb !== 3) $display("FAIL wr_busy_cycles actual=%0d required=3", nb); else pass_cnt++;
    total++; if (rd !== 32'h0) $display("FAIL wr_access_load actual=%h required=00000000", rd); else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (nb !== 3) $display("FAIL rd_busy_cycles actual=%0d required=3", nb); else pass_cnt++;
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_data actual=%h required=deadbeef", rd); else pass_cnt++;
    total++; if (early !== 32'h0) $display("FAIL rd_load_before_access actual=%h required=00000000", early); else pass_cnt++;
    #1;
    total++; if (load !== 32'h0) $display("FAIL rd_load_after_access actual=%h required=00000000", load); else pass_cnt++;
  endtask

  task automatic test_latency0();
    logic [31:0] rd, early; int nb;
    do_reset();
    do_access(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, rd, nb, early);
    total++; if (nb !== 1) $display("FAIL lat0_busy_cycles actual=%0d required=1", nb); else pass_cnt++;
    total++; if (rd !== 32'h0) $display("FAIL lat0_load actual=%h required=00000000", rd); else pass_cnt++;
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] rd, early; int nb;
    do_access(1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678, 1'b0, 1'b0, rd, nb, early);
    do_access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (rd !== 32'h1234_5678) $display("FAIL wrap_read actual=%h required=12345678", rd); else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [31:0] rd, early; int nb;
    do_access(1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 1'b0, 1'b0, rd, nb, early);
    total++; if (rd !== 32'h0) $display("FAIL both_is_write_load actual=%h required=00000000", rd); else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (rd !== 32'hA5A5_A5A5) $display("FAIL both_readback actual=%h required=a5a5a5a5", rd); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] rd, early; int nb;
    Wen = 1'b1; ramaddr = 32'h20; ramstore = 32'hFFFF_0000;
    step();
    total++; if (busy !== 1'b1) $display("FAIL abort_wait_busy actual=%b required=1", busy); else pass_cnt++;
    Wen = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy_drop actual=%b required=0", busy); else pass_cnt++;
    step(); step(); step();
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (rd !== 32'h0) $display("FAIL abort_no_write actual=%h required=00000000", rd); else pass_cnt++;
    // address change mid-WAIT: old word untouched, new word written
    Wen = 1'b1; ramaddr = 32'h50; ramstore = 32'h0BAD_F00D;
    step();
    do_access(1'b0, 1'b1, 32'h54, 32'h0BAD_F00D, 1'b0, 1'b0, rd, nb, early);
    total++; if (nb !== 4) $display("FAIL chg_busy_cycles actual=%0d required=4", nb); else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (rd !== 32'h0) $display("FAIL chg_old_addr actual=%h required=00000000", rd); else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h54, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (rd !== 32'h0BAD_F00D) $display("FAIL chg_new_addr actual=%h required=0badf00d", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, early; int nb;
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, rd, nb, early);
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL b2b_first actual=%h required=deadbeef", rd); else pass_cnt++;
    step();
    total++; if (busy !== 1'b1) $display("FAIL b2b_reaccept_busy actual=%b required=1", busy); else pass_cnt++;
    total++; if (load !== 32'h0) $display("FAIL b2b_idle_load actual=%h required=00000000", load); else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (nb !== 3 || rd !== 32'hDEAD_BEEF) $display("FAIL b2b_second actual=%0d/%h required=3/deadbeef", nb, rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, early; int nb;
    Wen = 1'b1; ramaddr = 32'h30; ramstore = 32'h3333_3333;
    step();
    nRST = 1'b0; Wen = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy actual=%b required=0", busy); else pass_cnt++;
    step(); step();
    nRST = 1'b1;
    step();
    do_access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (rd !== 32'h0) $display("FAIL rst_mid_no_write actual=%h required=00000000", rd); else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, rd, nb, early);
    total++; if (rd !== 32'h0) $display("FAIL rst_mid_cleared actual=%h required=00000000", rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency0();
    test_write_read();
    test_wrap();
    test_priority();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
